// File: rtl/dac_pkg.sv
// Shared constants and helpers for the serial DAC transmitter.
package dac_pkg;

    localparam int unsigned MODE_I2S = 0;
    localparam int unsigned MODE_LJ  = 1;

    function automatic int unsigned frame_bits(input int unsigned ch, input int unsigned slot_w);
        return ch * slot_w;
    endfunction

endpackage

// File: rtl/dac_bck_gen.sv
// Bit-clock divider: toggles bck every BCK_DIV clk cycles and strobes each 1->0 toggle.
module dac_bck_gen #(
    parameter int unsigned BCK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic bck,
    output logic fall
);

    localparam int unsigned DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tc;

    assign tc   = (div_cnt == DIV_LAST);
    assign fall = tc & bck;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_tdm_tx.sv
// Serial DAC transmitter: one-deep holding buffer feeding an I2S/left-justified/TDM shifter.
module dac_tdm_tx
    import dac_pkg::*;
#(
    parameter int unsigned DW            = 16,
    parameter int unsigned CH            = 2,
    parameter int unsigned SLOT_W        = 16,
    parameter int unsigned BCK_DIV       = 1,
    parameter int unsigned MODE          = 0,
    parameter int unsigned UNDERRUN_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*DW-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            dac_bck,
    output logic            dac_lrck,
    output logic            dac_data,
    output logic            frame_start,
    output logic            underrun
);

    localparam int unsigned FB = frame_bits(CH, SLOT_W);
    localparam int unsigned CW = $clog2(FB);
    localparam logic [CW-1:0] LAST_BIT = CW'(FB - 1);

    logic [CH*DW-1:0] hold_data;
    logic             hold_full;
    logic [FB-1:0]    hold_frame, new_frame, shifter, last_frame, sh_src, sh_next;
    logic [CW-1:0]    bit_cnt, next_bit;
    logic             started, fall, load, xfer, lrck_next, data_next;

    dac_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck (
        .clk  (clk),
        .rst  (rst),
        .bck  (dac_bck),
        .fall (fall)
    );

    for (genvar k = 0; k < CH; k++) begin : g_slot
        assign hold_frame[FB-1-k*SLOT_W -: SLOT_W] = SLOT_W'(hold_data[k*DW +: DW]) << (SLOT_W - DW);
    end

    assign xfer = s_valid & s_ready;
    assign load = fall & (~started | (bit_cnt == LAST_BIT));

    always_comb begin
        next_bit  = '0;
        new_frame = '0;
        lrck_next = 1'b0;
        sh_src    = shifter;
        sh_next   = shifter;
        data_next = 1'b0;

        if (started && bit_cnt != LAST_BIT)
            next_bit = bit_cnt + 1'b1;

        if (hold_full)
            new_frame = hold_frame;
        else if (UNDERRUN_ZERO == 0)
            new_frame = last_frame;

        if (CH == 2)
            lrck_next = (next_bit >= CW'(SLOT_W));
        else if (MODE == MODE_LJ)
            lrck_next = (next_bit == '0);
        else
            lrck_next = (next_bit == LAST_BIT);

        // I2S emits the shifter MSB before loading, so the previous frame's last bit
        // lands in bit 0 of the new frame; LJ emits the freshly loaded MSB directly.
        if (load)
            sh_src = new_frame;
        if (MODE == MODE_LJ) begin
            data_next = sh_src[FB-1];
            sh_next   = sh_src << 1;
        end else begin
            data_next = shifter[FB-1];
            sh_next   = load ? new_frame : (shifter << 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready     <= 1'b1;
            hold_full   <= 1'b0;
            hold_data   <= '0;
            shifter     <= '0;
            last_frame  <= '0;
            bit_cnt     <= '0;
            started     <= 1'b0;
            dac_lrck    <= 1'b0;
            dac_data    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (xfer)
                hold_data <= s_data;
            if (fall) begin
                started  <= 1'b1;
                bit_cnt  <= next_bit;
                dac_lrck <= lrck_next;
                dac_data <= data_next;
                shifter  <= sh_next;
            end
            if (load) begin
                last_frame  <= new_frame;
                frame_start <= 1'b1;
                underrun    <= ~hold_full;
                hold_full   <= xfer;
                s_ready     <= ~xfer;
            end else if (xfer) begin
                hold_full <= 1'b1;
                s_ready   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_tdm_tx.sv
// Directed self-checking bench for dac_tdm_tx: I2S stereo, repeat-on-underrun and 4-slot TDM variants.
module tb_dac_tdm_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_data, b_data;
    logic [95:0] c_data;
    logic        a_valid, b_valid, c_valid;
    logic        a_rdy, a_bck, a_lr, a_dat, a_fs, a_ur;
    logic        b_rdy, b_bck, b_lr, b_dat, b_fs, b_ur;
    logic        c_rdy, c_bck, c_lr, c_dat, c_fs, c_ur;
    logic [2:0]  rdy_v, bck_v, lr_v, dat_v, fs_v, ur_v;

    int          checks = 0;
    int          errors = 0;
    logic        bb_en, bb_bad;
    logic [31:0] acc[$];

    always #5 clk = ~clk;

    assign rdy_v = {c_rdy, b_rdy, a_rdy};
    assign bck_v = {c_bck, b_bck, a_bck};
    assign lr_v  = {c_lr,  b_lr,  a_lr};
    assign dat_v = {c_dat, b_dat, a_dat};
    assign fs_v  = {c_fs,  b_fs,  a_fs};
    assign ur_v  = {c_ur,  b_ur,  a_ur};

    dac_tdm_tx u_a (
        .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_rdy),
        .dac_bck(a_bck), .dac_lrck(a_lr), .dac_data(a_dat), .frame_start(a_fs), .underrun(a_ur)
    );

    dac_tdm_tx #(.UNDERRUN_ZERO(0)) u_b (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_rdy),
        .dac_bck(b_bck), .dac_lrck(b_lr), .dac_data(b_dat), .frame_start(b_fs), .underrun(b_ur)
    );

    dac_tdm_tx #(.DW(24), .CH(4), .SLOT_W(32), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .s_data(c_data), .s_valid(c_valid), .s_ready(c_rdy),
        .dac_bck(c_bck), .dac_lrck(c_lr), .dac_data(c_dat), .frame_start(c_fs), .underrun(c_ur)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk step; in back-to-back mode it also logs every handshake on instance A.
    task automatic tick();
        logic take;
        take = bb_en && a_valid && rdy_v[0];
        if (take) acc.push_back(a_data);
        @(posedge clk);
        #1;
        if (take) begin
            a_data = a_data + 32'h0001_0001;
            if (rdy_v[0] !== 1'b0) bb_bad = 1'b1;
        end
    endtask

    task automatic wait_fs(input int i, input string tag);
        int n;
        n = 0;
        while (fs_v[i] !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        chk(tag, {127'b0, fs_v[i]}, 128'd1);
    endtask

    // Starts at a frame_start sample point, ends at the next one.
    task automatic capture(input int i, input int nbits, input int dly,
                           output logic [127:0] rx, output logic [127:0] lr, output logic ok);
        rx = '0;
        lr = '0;
        ok = 1'b1;
        for (int n = 0; n <= nbits; n++) begin
            if (n >= dly && n < nbits + dly) rx = {rx[126:0], dat_v[i]};
            if (n < nbits) lr = {lr[126:0], lr_v[i]};
            if (bck_v[i] !== 1'b0) ok = 1'b0;
            if (n > 0 && n < nbits && fs_v[i] !== 1'b0) ok = 1'b0;
            if (n < nbits) begin
                tick();
                if (bck_v[i] !== 1'b1) ok = 1'b0;
                tick();
            end
        end
    endtask

    initial begin
        logic [127:0] rx, lr;
        logic         ok;
        logic [31:0]  v;
        logic         bad;

        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = '0; b_data = '0; c_data = '0;
        bb_en = 1'b0; bb_bad = 1'b0;
        tick();
        tick();
        chk("reset_ready", {125'b0, rdy_v}, 128'h7);
        chk("reset_outs", {113'b0, bck_v, lr_v, dat_v, fs_v, ur_v}, 128'h0);

        // Stereo I2S, sample presented before the first frame
        a_data = 32'h7FFE_8001;
        a_valid = 1'b1;
        rst = 1'b0;
        tick();
        a_valid = 1'b0;
        chk("t1_accept_ready", {127'b0, rdy_v[0]}, 128'd0);
        wait_fs(0, "t1_fs");
        chk("t1_fs_flags", {125'b0, ur_v[0], lr_v[0], rdy_v[0]}, 128'b001);
        capture(0, 32, 1, rx, lr, ok);
        chk("t1_data", rx, 128'h8001_7FFE);
        chk("t1_lrck", lr, 128'h0000_FFFF);
        chk("t1_timing", {127'b0, ok}, 128'd1);
        chk("t1_next_frame", {126'b0, fs_v[0], ur_v[0]}, 128'b11);

        // No samples: zeros out, underrun with every frame_start every 64 clk
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_fs(0, "t2_fs");
        chk("t2_underrun", {127'b0, ur_v[0]}, 128'd1);
        bad = 1'b0;
        for (int t = 1; t <= 128; t++) begin
            tick();
            if (dat_v[0] !== 1'b0) bad = 1'b1;
            if (fs_v[0] !== ((t % 64) == 0)) bad = 1'b1;
            if (ur_v[0] !== fs_v[0]) bad = 1'b1;
        end
        chk("t2_stream", {127'b0, bad}, 128'd0);

        // Repeat-last-frame on underrun
        rst = 1'b1;
        tick();
        b_data = 32'hABCD_1234;
        b_valid = 1'b1;
        rst = 1'b0;
        tick();
        b_valid = 1'b0;
        wait_fs(1, "t3_fs");
        chk("t3_first_ur", {127'b0, ur_v[1]}, 128'd0);
        capture(1, 32, 1, rx, lr, ok);
        chk("t3_frame1", rx, 128'h1234_ABCD);
        chk("t3_second_ur", {126'b0, fs_v[1], ur_v[1]}, 128'b11);
        capture(1, 32, 1, rx, lr, ok);
        chk("t3_frame2_repeat", rx, 128'h1234_ABCD);

        // 4-slot TDM, 24-bit samples in 32-bit slots, left-justified
        rst = 1'b1;
        tick();
        c_data = {24'h123456, 24'h800000, 24'h000001, 24'h7FFFFF};
        c_valid = 1'b1;
        rst = 1'b0;
        tick();
        c_valid = 1'b0;
        wait_fs(2, "t4_fs");
        chk("t4_fs_flags", {126'b0, ur_v[2], lr_v[2]}, 128'b01);
        capture(2, 128, 0, rx, lr, ok);
        chk("t4_data", rx, {24'h7FFFFF, 8'h00, 24'h000001, 8'h00, 24'h800000, 8'h00, 24'h123456, 8'h00});
        chk("t4_fsync", lr, {1'b1, 127'b0});
        chk("t4_timing", {127'b0, ok}, 128'd1);
        chk("t4_next_frame", {127'b0, fs_v[2]}, 128'd1);

        // Back-to-back with s_valid held high on instance A
        rst = 1'b1;
        tick();
        acc.delete();
        a_data = 32'h2000_1000;
        a_valid = 1'b1;
        bb_en = 1'b1;
        bb_bad = 1'b0;
        rst = 1'b0;
        wait_fs(0, "t5_fs");
        chk("t5_ready_at_fs", {126'b0, rdy_v[0], ur_v[0]}, 128'b10);
        for (int f = 0; f < 4; f++) begin
            capture(0, 32, 1, rx, lr, ok);
            v = acc[f];
            chk("t5_frame", rx, {96'b0, v[15:0], v[31:16]});
            chk("t5_fs_flags", {125'b0, fs_v[0], rdy_v[0], ur_v[0]}, 128'b110);
        end
        bb_en = 1'b0;
        a_valid = 1'b0;
        chk("t5_ready_drop", {127'b0, bb_bad}, 128'd0);
        chk("t5_accept_count", acc.size(), 128'd5);

        // Reset at bit 17 with a sample pending
        a_data = 32'h5555_AAAA;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        repeat (33) tick();
        chk("t6_mid_state", {126'b0, lr_v[0], rdy_v[0]}, 128'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_reset_outs", {122'b0, rdy_v[0], bck_v[0], lr_v[0], dat_v[0], fs_v[0], ur_v[0]}, 128'b100000);
        tick();
        chk("t6_pre_fs", {126'b0, bck_v[0], fs_v[0]}, 128'b10);
        tick();
        chk("t6_restart", {126'b0, fs_v[0], ur_v[0]}, 128'b11);
        capture(0, 32, 1, rx, lr, ok);
        chk("t6_discarded", rx, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
